seg_scan_display: RTL

Parametrised multiplexed multi-digit 7-segment display driver. Holds NUM_DIGITS packed BCD digits, scans them onto one shared segment bus with a one-hot digit enable at a programmable refresh rate, and commits new data only at frame boundaries so the display never tears. It succeeds the standalone combinational BCD-to-7-segment decoder and sits between the numeric datapath and the board's display pins.

---
 rtl/seg_scan_pkg.sv | 30 +++
 rtl/bcd_seg_decode.sv | 28 ++
 rtl/seg_scan_display.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver:
// segment bit positions, digit codes and the all-off pattern.
package seg_scan_pkg;

  localparam int SEG_W = 7;

  // Bit positions inside the {g,f,e,d,c,b,a} segment bus
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high segment codes
  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to active-high 7-segment decoder.
// Non-decimal codes 10..15 render as a centre dash.
module bcd_seg_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg
);

  // Digit lookup
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed NUM_DIGITS 7-segment scan driver; new data is committed only at frame wrap.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank zero digits above the most significant nonzero one).
module seg_scan_display
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_en,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  // Pin polarity masks; the inversion is applied as the very last step
  localparam logic [SEG_W-1:0]      SEG_POL = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [NUM_DIGITS-1:0] AN_POL  = SEG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic                  DP_POL  = SEG_ACTIVE_LOW;

  logic [DIV_W-1:0]        div_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_r;
  logic [4*NUM_DIGITS-1:0] active_bcd_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r;
  logic [NUM_DIGITS-1:0]   active_dp_r;
  logic                    pending_r;
  logic                    wrap_r;

  logic                    tick_s;
  logic                    wrap_s;
  logic [3:0]              cur_bcd_s;
  logic                    cur_dp_s;
  logic [NUM_DIGITS-1:0]   an_onehot_s;
  logic [SEG_W-1:0]        dec_seg_s;
  logic                    lz_blank_s;
  logic [SEG_W-1:0]        seg_nxt_s;
  logic [NUM_DIGITS-1:0]   an_nxt_s;
  logic                    dp_nxt_s;

  assign tick_s = (div_r == DIV_LAST);
  assign wrap_s = tick_s && (idx_r == IDX_LAST);

  // Select the digit, decimal point and enable for the current scan index
  always_comb begin
    cur_bcd_s   = 4'd0;
    cur_dp_s    = 1'b0;
    an_onehot_s = {NUM_DIGITS{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur_bcd_s      = (idx_r == IDX_W'(i)) ? active_bcd_r[4*i +: 4] : cur_bcd_s;
      cur_dp_s       = (idx_r == IDX_W'(i)) ? active_dp_r[i] : cur_dp_s;
      an_onehot_s[i] = (idx_r == IDX_W'(i));
    end
  end

  bcd_seg_decode u_decode (
    .bcd (cur_bcd_s),
    .seg (dec_seg_s)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above_s;

  // Digit i>0 is blank when it and every digit above it are zero
  always_comb begin
    zero_above_s = 1'b1;
    lz_blank_s   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above_s = zero_above_s & (active_bcd_r[4*i +: 4] == 4'd0);
      lz_blank_s   = (idx_r == IDX_W'(i)) ? zero_above_s : lz_blank_s;
    end
  end
`else
  assign lz_blank_s = 1'b0;
`endif

  // Active-high pin values before the output register
  always_comb begin
    if (blank_en) begin
      seg_nxt_s = SEG_OFF;
      an_nxt_s  = {NUM_DIGITS{1'b0}};
      dp_nxt_s  = 1'b0;
    end else begin
      seg_nxt_s = lz_blank_s ? SEG_OFF : dec_seg_s;
      an_nxt_s  = an_onehot_s;
      dp_nxt_s  = cur_dp_s;
    end
  end

  // Refresh divider and scan index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= {DIV_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else if (tick_s) begin
      div_r <= {DIV_W{1'b0}};
      idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Shadow/active data and commit at the frame wrap; a load on the wrap edge bypasses the shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_bcd_r <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r  <= {NUM_DIGITS{1'b0}};
      active_bcd_r <= {(4*NUM_DIGITS){1'b0}};
      active_dp_r  <= {NUM_DIGITS{1'b0}};
      pending_r    <= 1'b0;
      wrap_r       <= 1'b0;
    end else begin
      wrap_r <= wrap_s;
      if (load) begin
        shadow_bcd_r <= bcd_in;
        shadow_dp_r  <= dp_in;
      end else begin
        shadow_bcd_r <= shadow_bcd_r;
        shadow_dp_r  <= shadow_dp_r;
      end
      if (wrap_s) begin
        pending_r <= 1'b0;
        if (load) begin
          active_bcd_r <= bcd_in;
          active_dp_r  <= dp_in;
        end else if (pending_r) begin
          active_bcd_r <= shadow_bcd_r;
          active_dp_r  <= shadow_dp_r;
        end else begin
          active_bcd_r <= active_bcd_r;
          active_dp_r  <= active_dp_r;
        end
      end else begin
        pending_r <= pending_r | load;
      end
    end
  end

  // Output pins, one cycle behind the scan state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg            <= SEG_POL;
      dp             <= DP_POL;
      an             <= AN_POL;
      frame_done     <= 1'b0;
      update_pending <= 1'b0;
    end else begin
      seg            <= seg_nxt_s ^ SEG_POL;
      dp             <= dp_nxt_s ^ DP_POL;
      an             <= an_nxt_s ^ AN_POL;
      frame_done     <= wrap_r;
      update_pending <= pending_r;
    end
  end

endmodule
